// File: rtl/mux_rr_param.sv
// Parameterised N-channel multiplexer with a registered output stage.
// Each channel is picked either by a fixed selector or by round-robin search.
module mux_rr_param #(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          selector,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  input  logic                      ready_in,
  output logic [CHANNELS-1:0]       ack_out,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic [7:0]                count_out
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [7:0]       count_q, count_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;

  assign load_en = !valid_q || ready_in;

  // Round-robin search starts one past the last granted channel and wraps.
  always_comb begin
    int unsigned      idx;
    logic [SEL_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    if (!mode) begin
      if (int'(selector) < CHANNELS && valid_in[selector]) begin
        grant_vld = 1'b1;
        grant_idx = selector;
      end
    end else begin
      for (int unsigned i = 1; i <= CHANNELS; i++) begin
        idx  = (int'(rr_ptr_q) + i) % CHANNELS;
        cand = SEL_W'(idx);
        if (!grant_vld && valid_in[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    ack_out  = '0;
    data_d   = data_q;
    valid_d  = valid_q;
    chan_d   = chan_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (load_en) begin
      if (grant_vld) begin
        // Reset forces valid_q low, so ack must be masked explicitly.
        ack_out[grant_idx] = !reset;
        data_d   = data_in[int'(grant_idx)*WIDTH +: WIDTH];
        valid_d  = 1'b1;
        chan_d   = grant_idx;
        rr_ptr_d = grant_idx;
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      chan_q   <= '0;
      count_q  <= '0;
      rr_ptr_q <= SEL_W'(CHANNELS - 1);
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign chan_out  = chan_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_mux_rr_param.sv
// Directed bench for mux_rr_param (WIDTH=2, CHANNELS=4): vector table plus
// hand-written reset, round-robin, stall and saturation sequences.
module tb_mux_rr_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [1:0] selector;
  logic [7:0] data_in;
  logic [3:0] valid_in;
  logic       ready_in;
  logic [3:0] ack_out;
  logic [1:0] data_out;
  logic       valid_out;
  logic [1:0] chan_out;
  logic [7:0] count_out;

  int n_pass  = 0;
  int n_total = 0;

  mux_rr_param #(.WIDTH(2), .CHANNELS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .selector  (selector),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .ack_out   (ack_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .chan_out  (chan_out),
    .count_out (count_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_ack;
    logic [1:0] exp_data;
    logic       exp_valid;
    logic [1:0] exp_chan;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_regs(input string tag, input logic [1:0] d, input logic v,
                          input logic [1:0] c, input logic [7:0] n);
    chk({tag, ".data_out"},  32'(data_out),  32'(d));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(v));
    chk({tag, ".chan_out"},  32'(chan_out),  32'(c));
    chk({tag, ".count_out"}, 32'(count_out), 32'(n));
  endtask

  initial begin
    int exp_cnt;
    // ch0..ch3 data: 8'h39 -> 1,2,3,0 ; 8'hE4 -> 0,1,2,3
    vecs[0]  = '{1'b0, 2'd2, 8'h39, 4'b0100, 1'b1, 4'b0100, 2'd3, 1'b1, 2'd2, 8'd1};
    vecs[1]  = '{1'b0, 2'd1, 8'h39, 4'b0100, 1'b1, 4'b0000, 2'd3, 1'b0, 2'd2, 8'd1};
    vecs[2]  = '{1'b1, 2'd0, 8'hE4, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 2'd3, 8'd2};
    vecs[3]  = '{1'b1, 2'd0, 8'hE4, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1, 8'd3};
    vecs[4]  = '{1'b1, 2'd0, 8'hE4, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1, 2'd3, 8'd4};
    vecs[5]  = '{1'b1, 2'd0, 8'hE4, 4'b1111, 1'b0, 4'b0000, 2'd3, 1'b1, 2'd3, 8'd4};
    vecs[6]  = '{1'b1, 2'd0, 8'hE4, 4'b1111, 1'b0, 4'b0000, 2'd3, 1'b1, 2'd3, 8'd4};
    vecs[7]  = '{1'b0, 2'd0, 8'hE4, 4'b0001, 1'b0, 4'b0000, 2'd3, 1'b1, 2'd3, 8'd4};
    vecs[8]  = '{1'b0, 2'd0, 8'hE4, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0, 8'd5};
    vecs[9]  = '{1'b1, 2'd0, 8'hE4, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0, 8'd6};
    vecs[10] = '{1'b1, 2'd0, 8'hE4, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd6};
    vecs[11] = '{1'b1, 2'd0, 8'hE4, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd2, 8'd7};
    vecs[12] = '{1'b0, 2'd3, 8'hE4, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 2'd3, 8'd8};

    reset = 1'b1; mode = 1'b1; selector = 2'd0; data_in = 8'hE4;
    valid_in = 4'b1111; ready_in = 1'b1;
    #12;
    chk_regs("reset", 2'd0, 1'b0, 2'd0, 8'd0);
    chk("reset.ack_out", 32'(ack_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      mode = vecs[i].mode; selector = vecs[i].sel; data_in = vecs[i].data;
      valid_in = vecs[i].valid; ready_in = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d.ack_out", i), 32'(ack_out), 32'(vecs[i].exp_ack));
      @(posedge clk); #1;
      chk_regs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
               vecs[i].exp_chan, vecs[i].exp_count);
    end

    // Asynchronous reset between edges while a word is held.
    mode = 1'b1; valid_in = 4'b1111; data_in = 8'hE4; ready_in = 1'b1;
    #3 reset = 1'b1;
    #1;
    chk_regs("midreset", 2'd0, 1'b0, 2'd0, 8'd0);
    chk("midreset.ack_out", 32'(ack_out), 32'd0);
    @(posedge clk); #1;
    chk_regs("reset_edge", 2'd0, 1'b0, 2'd0, 8'd0);
    reset = 1'b0;

    // Round-robin after release: 0,1,2,3,0 then keep going to saturation.
    exp_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      chk($sformatf("rr%0d.ack_out", k), 32'(ack_out), 32'(4'b0001 << (k % 4)));
      @(posedge clk); #1;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk_regs($sformatf("rr%0d", k), 2'(k % 4), 1'b1, 2'(k % 4), 8'(exp_cnt));
    end

    // Fixed selector on an invalid channel: no grant, output drains.
    mode = 1'b0; selector = 2'd1; valid_in = 4'b1101;
    #1;
    chk("fixinv.ack_out", 32'(ack_out), 32'd0);
    @(posedge clk); #1;
    chk_regs("fixinv", 2'd3, 1'b0, 2'd3, 8'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/mux_rr_param.md
MUX_RR_PARAM -- requirements
Module: mux_rr_param

Interface
- REQ-001: Parameter WIDTH, default 2, bit width of each data channel.
- REQ-002: Parameter CHANNELS, default 4, number of input channels (legal 2..8).
- REQ-003: Derived constant SEL_W = clog2(CHANNELS), minimum 1.
- REQ-004: clk  input  1  sole clock; all state updates on rising edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: mode  input  1  0 = fixed select (selector), 1 = round-robin.
- REQ-007: selector  input  SEL_W  channel index used in fixed mode.
- REQ-008: data_in  input  CHANNELS*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
- REQ-009: valid_in  input  CHANNELS  per-channel data-valid flags.
- REQ-010: ready_in  input  1  downstream accepts data_out this cycle.
- REQ-011: ack_out  output  CHANNELS  one-hot, combinational; the channel consumed this cycle.
- REQ-012: data_out  output  WIDTH  registered selected data.
- REQ-013: valid_out  output  1  registered; data_out holds a word.
- REQ-014: chan_out  output  SEL_W  registered index of the channel that supplied data_out.
- REQ-015: count_out  output  8  registered, saturating count of accepted words.

Function
- REQ-016: Load enable SHALL be load_en = !valid_out || ready_in (combinational).
- REQ-017: Fixed mode: grant SHALL be channel selector when selector < CHANNELS and valid_in[selector] = 1; otherwise no grant.
- REQ-018: Round-robin mode: grant SHALL be the first channel with valid_in = 1, searching from (rr_ptr+1) mod CHANNELS upward with wrap-around; no grant when valid_in = 0.
- REQ-019: ack_out SHALL equal the one-hot of the grant when load_en = 1 and a grant exists, else all zeros.
- REQ-020: On a rising edge with load_en = 1 and grant g: data_out <= channel g data, chan_out <= g, valid_out <= 1, count_out increments by 1.
- REQ-021: On a rising edge with load_en = 1 and no grant: valid_out <= 0; data_out and chan_out hold.
- REQ-022: On a rising edge with load_en = 0 (stall): data_out, chan_out, valid_out, count_out SHALL hold; ack_out = 0.
- REQ-023: Latency SHALL be one clock: data acked in cycle n appears on data_out after edge n.
- REQ-024: rr_ptr SHALL update to g on every acked transfer, in either mode; it does not change otherwise.
- REQ-025: A mode change SHALL take effect in the same cycle's grant computation; rr_ptr is retained across mode changes.
- REQ-026: count_out SHALL saturate at 255 and not wrap.
- REQ-027: Back-to-back transfers SHALL sustain one word per clock when ready_in = 1.

Reset
- REQ-028: While reset = 1, regardless of clk: data_out = 0, valid_out = 0, chan_out = 0, count_out = 0, rr_ptr = CHANNELS-1; ack_out = 0.
- REQ-029: Reset asserted mid-transfer SHALL discard the held word; the first grant after release searches from channel 0.
- REQ-030: Release of reset SHALL be synchronous in effect: the first transfer occurs at the first rising edge with reset = 0.

Verification (WIDTH=2, CHANNELS=4)
- REQ-031: Fixed mode, selector=2, valid_in=4'b0100, channel 2 data=2'b11, ready_in=1 -> ack_out=4'b0100 same cycle; after edge data_out=2'b11, valid_out=1, chan_out=2, count_out=1.
- REQ-032: Round-robin, valid_in=4'b1111, ready_in=1 for 5 cycles after reset -> chan_out sequence 0,1,2,3,0; count_out=5.
- REQ-033: Round-robin, valid_in=4'b1010 -> chan_out sequence 1,3,1,3; ack_out never 4'b0001 or 4'b0100.
- REQ-034: valid_out=1, ready_in=0 for 3 cycles with all valid_in=1 -> data_out/chan_out held, ack_out=0, count_out unchanged; ready_in=1 resumes one transfer per clock.
- REQ-035: reset asserted between clock edges while valid_out=1 -> outputs zero immediately; after release with valid_in=4'b1111, round-robin mode, first chan_out=0.
- REQ-036: 300 consecutive transfers -> count_out reaches 255 and stays at 255; fixed mode with selector=1, valid_in[1]=0 -> valid_out falls to 0 after one edge.
